// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants for the elastic ID->EXE pipeline stage, including the
// control-bundle bit layout so every stage packs and unpacks it identically.
package pipe_skid_stage_pkg;

  localparam int PIPE_CTRL_LEN  = 8;
  localparam int PIPE_DATA_LEN  = 128;
  localparam int PIPE_DEPTH_MAX = 2;
  localparam int PIPE_CNT_LEN   = 16;

  localparam int CTRL_WB_EN = 0;
  localparam int CTRL_MEM_R = 1;
  localparam int CTRL_MEM_W = 2;
  localparam int CTRL_B     = 3;
  localparam int CTRL_S     = 4;
  localparam int CTRL_IMM   = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake carrying one instruction's control and payload bundles.
interface pipe_skid_stage_if
  import pipe_skid_stage_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_LEN,
  parameter int DATA_W = PIPE_DATA_LEN
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_skid_stage_slot.sv
// One storage entry of the stage: ctrl+data register with load and a
// ctrl-only clear so killed slots can never write back, access memory or branch.
module pipe_slot
  import pipe_skid_stage_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_LEN,
  parameter int DATA_W = PIPE_DATA_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              ctrl_clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear wins over load so a killed entry always ends with zero control.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (ld) begin
      ctrl_d = d_ctrl;
      data_d = d_data;
    end
    if (ctrl_clr) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign q_ctrl = ctrl_q;
  assign q_data = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with freeze/flush and an optional skid entry
// that keeps out_ready off the in_ready path; also counts stalled cycles.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_LEN,
  parameter int DATA_W = PIPE_DATA_LEN,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = PIPE_CNT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             stall_cnt_clr,
  pipe_skid_stage_if.slave  in_if,
  pipe_skid_stage_if.master out_if,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_skid_stage: DEPTH must be 1 or 2");
  end

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  occ_e              occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_ready, out_valid, in_fire, out_fire;
  logic              ld0, ld1, clr0, clr1, sel_skid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_d_ctrl;
  logic [DATA_W-1:0] head_data, skid_data, head_d_data;

  assign in_ready  = ~freeze & ((DEPTH == 2) ? (occ_q != OCC_FULL)
                                             : ((occ_q == OCC_EMPTY) | out_if.ready));
  assign out_valid = (occ_q != OCC_EMPTY) & ~freeze;
  assign in_fire   = in_if.valid & in_ready;
  assign out_fire  = out_valid & out_if.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      stall_q <= '0;
    end else begin
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end

  // Flush drops any same-cycle input but lets a same-cycle output complete.
  always_comb begin
    occ_d    = occ_q;
    ld0      = 1'b0;
    ld1      = 1'b0;
    clr0     = 1'b0;
    clr1     = 1'b0;
    sel_skid = 1'b0;
    if (flush) begin
      occ_d = OCC_EMPTY;
      clr0  = 1'b1;
      clr1  = 1'b1;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            ld0   = 1'b1;
            occ_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            ld0 = 1'b1;
          end else if (in_fire) begin
            ld1   = 1'b1;
            occ_d = OCC_FULL;
          end else if (out_fire) begin
            clr0  = 1'b1;
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            ld0      = 1'b1;
            sel_skid = 1'b1;
            clr1     = 1'b1;
            occ_d    = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_cnt_clr) begin
      stall_d = '0;
    end else if ((occ_q != OCC_EMPTY) && (!out_if.ready || freeze) && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign head_d_ctrl = sel_skid ? skid_ctrl : in_if.ctrl;
  assign head_d_data = sel_skid ? skid_data : in_if.data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld0),
    .ctrl_clr (clr0),
    .d_ctrl   (head_d_ctrl),
    .d_data   (head_d_data),
    .q_ctrl   (head_ctrl),
    .q_data   (head_data)
  );

  if (DEPTH == 2) begin : g_skid
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld1),
      .ctrl_clr (clr1),
      .d_ctrl   (in_if.ctrl),
      .d_data   (in_if.data),
      .q_ctrl   (skid_ctrl),
      .q_data   (skid_data)
    );
  end else begin : g_no_skid
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.ctrl  = out_valid ? head_ctrl : '0;
  assign out_if.data  = head_data;
  assign occupancy    = occ_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Drives a DEPTH=2 and a DEPTH=1 stage with identical stimulus and compares
// both against a small FIFO-level reference model every cycle.
module tb_pipe_skid_stage;
  import pipe_skid_stage_pkg::*;

  localparam int CW = 8;
  localparam int DW = 128;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          curFl = 1'b0, curFr = 1'b0, curIv = 1'b0, curOrdy = 1'b0, curClr = 1'b0;
  logic [CW-1:0] curCtrl = '0;
  logic [DW-1:0] curData = '0;

  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) in2 ();
  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) out2 ();
  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) in1 ();
  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) out1 ();

  assign in2.valid  = curIv;
  assign in2.ctrl   = curCtrl;
  assign in2.data   = curData;
  assign out2.ready = curOrdy;
  assign in1.valid  = curIv;
  assign in1.ctrl   = curCtrl;
  assign in1.data   = curData;
  assign out1.ready = curOrdy;

  logic [1:0]    occ2, occ1;
  logic [SW-1:0] stall2, stall1;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CNT_W(SW)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .flush         (curFl),
    .freeze        (curFr),
    .stall_cnt_clr (curClr),
    .in_if         (in2),
    .out_if        (out2),
    .occupancy     (occ2),
    .stall_cnt     (stall2)
  );

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CNT_W(SW)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .flush         (curFl),
    .freeze        (curFr),
    .stall_cnt_clr (curClr),
    .in_if         (in1),
    .out_if        (out1),
    .occupancy     (occ1),
    .stall_cnt     (stall1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 models DEPTH=2, index 1 models DEPTH=1.
  logic [CW-1:0] mCtrl [2][2];
  logic [DW-1:0] mData [2][2];
  logic [DW-1:0] mLast [2];
  int            mCnt  [2];
  int            mStall[2];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic mReady(int k);
    if (curFr) return 1'b0;
    if (k == 0) return mCnt[k] < 2;
    return (mCnt[k] == 0) || curOrdy;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0;
      mStall[k] = 0;
      mLast[k] = '0;
      for (int j = 0; j < 2; j++) begin
        mCtrl[k][j] = '0;
        mData[k][j] = '0;
      end
    end
  endtask

  task automatic checkDut(int k);
    logic          ov;
    string         pre;
    logic          gotRdy, gotVld;
    logic [CW-1:0] gotCtrl;
    logic [DW-1:0] gotData;
    logic [1:0]    gotOcc;
    logic [SW-1:0] gotStall;
    pre      = (k == 0) ? "d2" : "d1";
    gotRdy   = (k == 0) ? in2.ready  : in1.ready;
    gotVld   = (k == 0) ? out2.valid : out1.valid;
    gotCtrl  = (k == 0) ? out2.ctrl  : out1.ctrl;
    gotData  = (k == 0) ? out2.data  : out1.data;
    gotOcc   = (k == 0) ? occ2       : occ1;
    gotStall = (k == 0) ? stall2     : stall1;
    ov = (mCnt[k] != 0) && !curFr;
    checkOutput({pre, "_in_ready"},  DW'(gotRdy),  DW'(mReady(k)));
    checkOutput({pre, "_out_valid"}, DW'(gotVld),  DW'(ov));
    checkOutput({pre, "_out_ctrl"},  DW'(gotCtrl), ov ? DW'(mCtrl[k][0]) : '0);
    checkOutput({pre, "_out_data"},  gotData,      mLast[k]);
    checkOutput({pre, "_occupancy"}, DW'(gotOcc),  DW'(mCnt[k]));
    checkOutput({pre, "_stall_cnt"}, DW'(gotStall), DW'(mStall[k]));
  endtask

  task automatic stepModel(int k);
    logic rdy, ov, inF, outF;
    rdy  = mReady(k);
    ov   = (mCnt[k] != 0) && !curFr;
    inF  = curIv && rdy;
    outF = ov && curOrdy;
    if (curClr) mStall[k] = 0;
    else if ((mCnt[k] != 0) && (!curOrdy || curFr) && (mStall[k] < (1 << SW) - 1)) mStall[k]++;
    if (curFl) begin
      mCnt[k] = 0;
    end else begin
      if (outF) begin
        mCtrl[k][0] = mCtrl[k][1];
        mData[k][0] = mData[k][1];
        mCnt[k]--;
      end
      if (inF) begin
        mCtrl[k][mCnt[k]] = curCtrl;
        mData[k][mCnt[k]] = curData;
        mCnt[k]++;
      end
      if (mCnt[k] > 0) mLast[k] = mData[k][0];
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic fr, input logic iv,
                               input logic [CW-1:0] ic, input logic [DW-1:0] id,
                               input logic ordy, input logic clr);
    curFl = fl; curFr = fr; curIv = iv; curCtrl = ic; curData = id;
    curOrdy = ordy; curClr = clr;
    #2;
    checkDut(0);
    checkDut(1);
    stepModel(0);
    stepModel(1);
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] d1, d2, d3, rnd;

  initial begin
    d1 = {4{32'h1111_1111}};
    d2 = {4{32'h2222_2222}};
    d3 = {4{32'h3333_3333}};
    resetModel();

    #12;
    checkOutput("rst_occupancy", DW'(occ2), '0);
    checkOutput("rst_out_valid", DW'(out2.valid), '0);
    checkOutput("rst_out_ctrl",  DW'(out2.ctrl), '0);
    checkOutput("rst_out_data",  out2.data, '0);
    checkOutput("rst_stall_cnt", DW'(stall2), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pass-through with one-cycle latency.
    applyStimulus(0, 0, 1, 8'h3F, d1, 1, 0);
    checkOutput("tp1_out_ctrl", DW'(out2.ctrl), DW'(8'h3F));
    checkOutput("tp1_out_data", out2.data, d1);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);
    checkOutput("tp1_drain_occ", DW'(occ2), '0);

    // Back-pressure fills the skid entry, then FIFO drain.
    applyStimulus(0, 0, 1, 8'h11, d1, 0, 0);
    applyStimulus(0, 0, 1, 8'h22, d2, 0, 0);
    checkOutput("tp2_full_occ", DW'(occ2), DW'(2'd2));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h33, d3, 0, 0);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);
    checkOutput("tp2_second_out", out2.data, d2);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);

    // Freeze a full stage while downstream is ready.
    applyStimulus(0, 0, 1, 8'h44, d1, 0, 0);
    applyStimulus(0, 0, 1, 8'h55, d2, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 8'h66, d3, 1, 0);
    applyStimulus(0, 0, 0, '0, '0, 1, 0);
    applyStimulus(0, 0, 0, '0, '0, 0, 0);

    // Flush a full stage with a competing input.
    applyStimulus(0, 0, 1, 8'h77, d3, 0, 0);
    applyStimulus(1, 0, 1, 8'h01, d1, 0, 0);
    checkOutput("tp4_flush_occ",  DW'(occ2), '0);
    checkOutput("tp4_flush_ctrl", DW'(out2.ctrl), '0);
    applyStimulus(0, 0, 0, '0, '0, 0, 0);

    // Saturate the stall counter, then clear it during a stall.
    applyStimulus(0, 0, 1, 8'h0F, d2, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, '0, '0, 0, 0);
    checkOutput("tp5_stall_sat", DW'(stall2), DW'(4'hF));
    applyStimulus(0, 0, 0, '0, '0, 0, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 0);

    // Asynchronous reset between edges while full.
    applyStimulus(0, 0, 1, 8'h5A, d3, 0, 0);
    checkOutput("tp6_pre_occ", DW'(occ2), DW'(2'd2));
    curIv = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("tp6_async_valid", DW'(out2.valid), '0);
    checkOutput("tp6_async_ctrl",  DW'(out2.ctrl), '0);
    checkOutput("tp6_async_occ",   DW'(occ2), '0);
    checkOutput("tp6_async_stall", DW'(stall2), '0);
    resetModel();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom % 20) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                    CW'($urandom), rnd, ($urandom % 3) != 0, ($urandom % 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
